switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Upstream conditioning stage for the board slide-switch/push-button inputs in[4:0].
//  Synchronises each asynchronous raw input into the clk_100mhz domain and debounces it.
//  Outputs a clean level per bit plus optional one-cycle edge pulses.
//  Feeds the combinational LED logic and any future counter/control logic.
// PARAMETERS
//  WIDTH        5            number of independent input bits
//  CLK_HZ       100000000    clk_100mhz frequency in Hz
//  DEBOUNCE_MS  10           required stable time in ms
//  SYNC_STAGES  2            synchroniser flops per bit, legal range 2..4
//  RESET_VALUE  '0           reset value of in_clean (WIDTH bits)
//  Derived: COUNT_MAX = CLK_HZ/1000*DEBOUNCE_MS. Elaboration error if COUNT_MAX < 2.
//  Derived: CNT_W = $clog2(COUNT_MAX).
// PORTS
//  clk_100mhz  in   1      system clock from the PLL
//  rst_n       in   1      asynchronous active-low reset; assert async, release sync to clk_100mhz externally
//  in_raw      in   WIDTH  raw pad inputs, asynchronous, may bounce
//  in_clean    out  WIDTH  debounced level
//  rise_pulse  out  WIDTH  1-cycle pulse when in_clean bit goes 0->1
//  fall_pulse  out  WIDTH  1-cycle pulse when in_clean bit goes 1->0
//  all_stable  out  1      1 when no bit has a pending change, i.e. every counter is idle
// BEHAVIOUR
//  Reset (rst_n=0, async): sync flops = RESET_VALUE, in_clean = RESET_VALUE.
//  Reset also clears counters, sets rise/fall_pulse = 0 and all_stable = 1.
//  Per bit, s = last synchroniser stage. FSM has two states, IDLE and PENDING. Counter cnt is CNT_W bits.
//  IDLE: if s == in_clean, stay; else go to PENDING with cnt <= 1.
//  PENDING: if s == in_clean (bounce back), go to IDLE with cnt <= 0 and no output change.
//  PENDING: else if cnt == COUNT_MAX-1, then in_clean <= s, go to IDLE, cnt <= 0.
//  PENDING: else cnt <= cnt+1.
//  in_clean toggles after exactly COUNT_MAX consecutive edges with s != in_clean.
//  Latency from a clean raw step to in_clean = SYNC_STAGES + COUNT_MAX clock edges.
//  rise/fall_pulse are registered and assert in the cycle after in_clean changes.
//  Each pulse is high for exactly 1 cycle and never asserts in the same cycle as the other for one bit.
//  Any single-cycle glitch or bounce shorter than COUNT_MAX cycles never reaches in_clean. The counter restarts on each bounce.
//  Bits are fully independent. Simultaneous changes on several bits resolve independently.
//  all_stable = AND over bits of (state == IDLE), registered.
//  cnt never wraps; it saturates by construction at COUNT_MAX-1.
//  Reset mid-count discards the pending change.
//  If in_raw != RESET_VALUE at reset release, in_clean follows after the normal latency and emits the normal edge pulse.
// CONFIGURATION
//  SWITCH_DEBOUNCER_EDGES_EN defined: rise_pulse and fall_pulse are generated as above.
//  Not defined: rise_pulse and fall_pulse are tied to '0, and no edge registers are synthesised.
//  Ports are present in both builds.
// STRUCTURE
//  Shared package simple_fpga_cvs_pkg holds:
//   - localparam CLK_100MHZ_HZ = 100000000;
//   - typedef enum logic {DB_IDLE, DB_PENDING} db_state_t;
//   - function ms_to_cycles(int hz, int ms).
//  Sub-module debounce_bit holds one bit's synchroniser, FSM, counter and edge detect.
//  It is instantiated WIDTH times in a generate loop. The top level does the all_stable reduction.
// TESTING
//  Bench configuration: CLK_HZ=1000, DEBOUNCE_MS=4, so COUNT_MAX=4; SYNC_STAGES=2; WIDTH=5.
//  T1 reset: rst_n=0 mid-cycle with in_raw=5'h1F.
//     -> in_clean=0, pulses 0, all_stable=1 immediately, without waiting for a clock edge.
//  T2 clean step: in_raw[0] 0->1 held.
//     -> in_clean[0]=1 exactly 6 edges later; rise_pulse[0] high 1 cycle on the next edge; all_stable low during the count.
//  T3 bounce: in_raw[1] toggles 1,0,1,0,1 with 2 cycles per level, then holds 1.
//     -> in_clean[1] rises only 6 edges after the final rise; exactly 1 rise_pulse.
//  T4 glitch: in_raw[2] high for 3 cycles then low.
//     -> in_clean[2] stays 0; no pulses; all_stable returns to 1.
//  T5 simultaneous: in_raw 5'h00 -> 5'h1F in one cycle.
//     -> all bits of in_clean rise on the same edge; rise_pulse=5'h1F for 1 cycle.
//  T6 reset mid-count: in_raw[3]=1, assert rst_n after 3 edges.
//     -> in_clean[3]=0; after release the full 6-edge latency restarts.
//  Run both builds. Without SWITCH_DEBOUNCER_EDGES_EN, assert rise/fall_pulse == 0 throughout.

Source files
------------

// File: rtl/simple_fpga_cvs_pkg.sv
// Shared types and helpers for the board input conditioning logic.
package simple_fpga_cvs_pkg;

    localparam int unsigned CLK_100MHZ_HZ = 100000000;

    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    // Number of clock cycles in a given number of milliseconds.
    function automatic int ms_to_cycles(input int hz, input int ms);
        return (hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Raw switch inputs and their conditioned level/edge outputs.
interface switch_debouncer_if #(
    parameter int unsigned WIDTH = 5
);
    logic [WIDTH-1:0] in_raw;
    logic [WIDTH-1:0] in_clean;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             all_stable;

    modport master (
        output in_raw,
        input  in_clean,
        input  rise_pulse,
        input  fall_pulse,
        input  all_stable
    );

    modport slave (
        input  in_raw,
        output in_clean,
        output rise_pulse,
        output fall_pulse,
        output all_stable
    );
endinterface

// File: rtl/debounce_bit.sv
// One input bit: synchroniser, IDLE/PENDING debounce FSM with stability counter,
// and optional edge pulses (SWITCH_DEBOUNCER_EDGES_EN).
module debounce_bit
    import simple_fpga_cvs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_MAX   = 4,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic idle_c
);

    localparam int unsigned     CNT_W    = $clog2(COUNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state;
    logic [CNT_W-1:0]       cnt;

    // Metastability synchroniser; s is the last stage.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any return of s to the current level restarts the stability window.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= DB_IDLE;
            cnt   <= '0;
            clean <= RESET_VAL;
        end else begin
            case (state)
                DB_IDLE: begin
                    if (s != clean) begin
                        state <= DB_PENDING;
                        cnt   <= CNT_W'(1);
                    end
                end
                DB_PENDING: begin
                    if (s == clean) begin
                        state <= DB_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        clean <= s;
                        state <= DB_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= DB_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign idle_c = (state == DB_IDLE);

`ifdef SWITCH_DEBOUNCER_EDGES_EN
    logic clean_d;

    // Pulses land one cycle after the clean level changes.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            clean_d <= RESET_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            clean_d <= clean;
            rise    <= clean & ~clean_d;
            fall    <= ~clean & clean_d;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous switch inputs into the clk_100mhz domain.
// Define SWITCH_DEBOUNCER_EDGES_EN to generate rise/fall pulses.
module switch_debouncer
    import simple_fpga_cvs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 5,
    parameter int unsigned      CLK_HZ      = CLK_100MHZ_HZ,
    parameter int unsigned      DEBOUNCE_MS = 10,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic           clk_100mhz,
    input  logic           rst_n,
    switch_debouncer_if.slave sw
);

    localparam int unsigned COUNT_MAX = 32'(ms_to_cycles(int'(CLK_HZ), int'(DEBOUNCE_MS)));

    if (COUNT_MAX < 2) begin : g_bad_count
        $error("switch_debouncer: COUNT_MAX must be at least 2");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("switch_debouncer: SYNC_STAGES must be in 2..4");
    end

    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] idle_w;
    logic             all_stable_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .COUNT_MAX   (COUNT_MAX),
            .RESET_VAL   (RESET_VALUE[i])
        ) u_bit (
            .clk_100mhz (clk_100mhz),
            .rst_n      (rst_n),
            .raw        (sw.in_raw[i]),
            .clean      (clean_w[i]),
            .rise       (rise_w[i]),
            .fall       (fall_w[i]),
            .idle_c     (idle_w[i])
        );
    end

    // High only when no bit has a change in flight.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            all_stable_q <= 1'b1;
        end else begin
            all_stable_q <= &idle_w;
        end
    end

    assign sw.in_clean   = clean_w;
    assign sw.rise_pulse = rise_w;
    assign sw.fall_pulse = fall_w;
    assign sw.all_stable = all_stable_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with COUNT_MAX=4, SYNC_STAGES=2, WIDTH=5.
module tb_switch_debouncer;

    localparam int unsigned W = 5;
`ifdef SWITCH_DEBOUNCER_EDGES_EN
    localparam bit EDGES_EN = 1'b1;
`else
    localparam bit EDGES_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] exp_clean;
        logic         exp_stable;
    } vec_t;

    typedef struct {
        logic [W-1:0] clean;
        logic         stable;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    switch_debouncer_if #(.WIDTH(W)) sw ();

    switch_debouncer #(
        .WIDTH       (W),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .SYNC_STAGES (2),
        .RESET_VALUE ('0)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .sw         (sw.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;
    int rise_cnt [W];
    int fall_cnt [W];
    logic [W-1:0] prev_rise = '0;
    logic [W-1:0] prev_fall = '0;

    vec_t vecs [13];
    exp_t sb_q [$];
    exp_t e;
    int   edges;
    bit   path_ok, saw_unstable, seen;
    int   r_snap, f_snap;
    int   base_rise [W];
    int   base_fall [W];
    int   exp_rise  [W];
    int   exp_fall  [W];
    logic [W-1:0] prev_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: sample just after the edge and track pulse behaviour.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_rise = '0;
            prev_fall = '0;
        end else begin
            for (int i = 0; i < int'(W); i++) begin
                if (sw.rise_pulse[i]) rise_cnt[i]++;
                if (sw.fall_pulse[i]) fall_cnt[i]++;
            end
            if ((sw.rise_pulse & prev_rise) != '0) viol++;
            if ((sw.fall_pulse & prev_fall) != '0) viol++;
            if ((sw.rise_pulse & sw.fall_pulse) != '0) viol++;
            if (!EDGES_EN && (sw.rise_pulse | sw.fall_pulse) != '0) viol++;
            prev_rise = sw.rise_pulse;
            prev_fall = sw.fall_pulse;
        end
    endtask

    // Counts edges until the masked clean level reaches target (-1 on timeout).
    task automatic wait_clean(input logic [W-1:0] mask, input logic [W-1:0] target,
                              output int n_edges, output bit direct, output bit unstable);
        logic [W-1:0] start;
        start    = sw.in_clean & mask;
        n_edges  = -1;
        direct   = 1'b1;
        unstable = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (!sw.all_stable) unstable = 1'b1;
            if ((sw.in_clean & mask) == target) begin
                n_edges = n;
                break;
            end
            if ((sw.in_clean & mask) != start) direct = 1'b0;
        end
    endtask

    task automatic settle();
        sw.in_raw = '0;
        repeat (12) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{5'h00, 4, 5'h00, 1'b1};
        vecs[1]  = '{5'h01, 5, 5'h00, 1'b0};
        vecs[2]  = '{5'h01, 1, 5'h01, 1'b0};
        vecs[3]  = '{5'h01, 2, 5'h01, 1'b1};
        vecs[4]  = '{5'h0A, 7, 5'h0A, 1'b1};
        vecs[5]  = '{5'h0E, 3, 5'h0A, 1'b1};
        vecs[6]  = '{5'h0A, 3, 5'h0A, 1'b0};
        vecs[7]  = '{5'h0A, 6, 5'h0A, 1'b1};
        vecs[8]  = '{5'h15, 7, 5'h15, 1'b1};
        vecs[9]  = '{5'h1F, 3, 5'h15, 1'b1};
        vecs[10] = '{5'h15, 3, 5'h15, 1'b0};
        vecs[11] = '{5'h15, 6, 5'h15, 1'b1};
        vecs[12] = '{5'h00, 7, 5'h00, 1'b1};
        for (int i = 0; i < int'(W); i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end

        // T1: asynchronous reset between clock edges
        rst_n     = 1'b1;
        sw.in_raw = 5'h1F;
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_clean",  32'(sw.in_clean),   32'(5'h00));
        check("t1_rise",   32'(sw.rise_pulse), 32'(5'h00));
        check("t1_fall",   32'(sw.fall_pulse), 32'(5'h00));
        check("t1_stable", 32'(sw.all_stable), 32'(1'b1));
        repeat (2) tick();
        check("t1_hold_clean", 32'(sw.in_clean), 32'(5'h00));

        // Release with inputs away from the reset value
        @(negedge clk);
        rst_n = 1'b1;
        wait_clean(5'h1F, 5'h1F, edges, path_ok, saw_unstable);
        check("rel_latency", 32'(edges), 32'(6));
        tick();
        check("rel_rise", 32'(sw.rise_pulse), 32'(EDGES_EN ? 5'h1F : 5'h00));
        tick();
        check("rel_rise_end", 32'(sw.rise_pulse), 32'(5'h00));
        settle();
        check("rel_settle", 32'(sw.in_clean), 32'(5'h00));

        // T2: clean step on bit 0
        sw.in_raw = 5'h01;
        wait_clean(5'h01, 5'h01, edges, path_ok, saw_unstable);
        check("t2_latency",  32'(edges), 32'(6));
        check("t2_unstable", 32'(saw_unstable), 32'(1'b1));
        tick();
        check("t2_rise", 32'(sw.rise_pulse), 32'(EDGES_EN ? 5'h01 : 5'h00));
        check("t2_fall", 32'(sw.fall_pulse), 32'(5'h00));
        check("t2_stable", 32'(sw.all_stable), 32'(1'b1));
        tick();
        check("t2_rise_end", 32'(sw.rise_pulse), 32'(5'h00));
        settle();

        // T3: bounce on bit 1, 2 cycles per level, then held high
        r_snap = rise_cnt[1];
        seen   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw.in_raw[1] = (k % 2 == 0);
            repeat (2) begin
                tick();
                if (sw.in_clean[1]) seen = 1'b1;
            end
        end
        check("t3_no_leak", 32'(seen), 32'(1'b0));
        sw.in_raw[1] = 1'b1;
        wait_clean(5'h02, 5'h02, edges, path_ok, saw_unstable);
        check("t3_latency", 32'(edges), 32'(6));
        repeat (3) tick();
        check("t3_rise_count", 32'(rise_cnt[1] - r_snap), 32'(EDGES_EN ? 1 : 0));
        settle();

        // T4: 3-cycle glitch on bit 2 never reaches the output
        r_snap = rise_cnt[2];
        f_snap = fall_cnt[2];
        seen   = 1'b0;
        sw.in_raw[2] = 1'b1;
        repeat (3) tick();
        sw.in_raw[2] = 1'b0;
        repeat (12) begin
            tick();
            if (sw.in_clean[2]) seen = 1'b1;
        end
        check("t4_no_leak", 32'(seen), 32'(1'b0));
        check("t4_pulses", 32'((rise_cnt[2] - r_snap) + (fall_cnt[2] - f_snap)), 32'(0));
        check("t4_stable", 32'(sw.all_stable), 32'(1'b1));

        // A 4-cycle pulse is exactly long enough to pass
        r_snap = rise_cnt[4];
        seen   = 1'b0;
        sw.in_raw[4] = 1'b1;
        repeat (4) tick();
        sw.in_raw[4] = 1'b0;
        repeat (12) begin
            tick();
            if (sw.in_clean[4]) seen = 1'b1;
        end
        check("min_pulse_passes", 32'(seen), 32'(1'b1));
        check("min_pulse_back",   32'(sw.in_clean), 32'(5'h00));
        check("min_pulse_rise",   32'(rise_cnt[4] - r_snap), 32'(EDGES_EN ? 1 : 0));

        // T5: all bits change together
        sw.in_raw = 5'h1F;
        wait_clean(5'h1F, 5'h1F, edges, path_ok, saw_unstable);
        check("t5_latency", 32'(edges), 32'(6));
        check("t5_same_edge", 32'(path_ok), 32'(1'b1));
        tick();
        check("t5_rise", 32'(sw.rise_pulse), 32'(EDGES_EN ? 5'h1F : 5'h00));
        sw.in_raw = 5'h00;
        wait_clean(5'h1F, 5'h00, edges, path_ok, saw_unstable);
        check("t5_fall_latency", 32'(edges), 32'(6));
        tick();
        check("t5_fall", 32'(sw.fall_pulse), 32'(EDGES_EN ? 5'h1F : 5'h00));
        settle();

        // T6: reset in the middle of a count
        sw.in_raw = 5'h08;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_clean", 32'(sw.in_clean), 32'(5'h00));
        check("t6_stable", 32'(sw.all_stable), 32'(1'b1));
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        wait_clean(5'h08, 5'h08, edges, path_ok, saw_unstable);
        check("t6_latency", 32'(edges), 32'(6));
        tick();
        check("t6_rise", 32'(sw.rise_pulse), 32'(EDGES_EN ? 5'h08 : 5'h00));
        settle();

        // Table-driven patterns through the scoreboard
        for (int i = 0; i < int'(W); i++) begin
            base_rise[i] = rise_cnt[i];
            base_fall[i] = fall_cnt[i];
            exp_rise[i]  = 0;
            exp_fall[i]  = 0;
        end
        prev_exp = sw.in_clean;
        for (int v = 0; v < 13; v++) begin
            sw.in_raw = vecs[v].raw;
            sb_q.push_back('{vecs[v].exp_clean, vecs[v].exp_stable});
            for (int i = 0; i < int'(W); i++) begin
                if (!prev_exp[i] &&  vecs[v].exp_clean[i]) exp_rise[i]++;
                if ( prev_exp[i] && !vecs[v].exp_clean[i]) exp_fall[i]++;
            end
            prev_exp = vecs[v].exp_clean;
            repeat (vecs[v].hold) tick();
            e = sb_q.pop_front();
            check($sformatf("vec%0d_clean", v),  32'(sw.in_clean),   32'(e.clean));
            check($sformatf("vec%0d_stable", v), 32'(sw.all_stable), 32'(e.stable));
        end
        for (int i = 0; i < int'(W); i++) begin
            check($sformatf("vec_rise_count_b%0d", i), 32'(rise_cnt[i] - base_rise[i]),
                  32'(EDGES_EN ? exp_rise[i] : 0));
            check($sformatf("vec_fall_count_b%0d", i), 32'(fall_cnt[i] - base_fall[i]),
                  32'(EDGES_EN ? exp_fall[i] : 0));
        end

        check("pulse_shape_violations", 32'(viol), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
